// File: rtl/msrv32_dmem_arbiter_if.sv
// Requester-side data-memory handshake shared by the core load/store path and the DMA/debug port.
// master: the requester; slave: the arbiter.
interface msrv32_dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, mask,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, mask,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/msrv32_dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port: registered transactions, wait states,
// core stall. Define DMEM_TIMEOUT_EN to abort accesses stuck in BUSY for TimeoutCycles cycles.
module msrv32_dmem_arbiter #(
  parameter int unsigned StarveLimit = 4
`ifdef DMEM_TIMEOUT_EN
  , parameter int unsigned TimeoutCycles = 255
`endif
) (
  input  logic                        ms_riscv32_mp_clk_in,
  input  logic                        ms_riscv32_mp_rst_n_in,
  msrv32_dmem_arbiter_if.slave        core_io,
  msrv32_dmem_arbiter_if.slave        dma_io,
  output logic                        core_stall_out,
  output logic [31:0]                 ms_riscv32_mp_dmaddr_out,
  output logic [31:0]                 ms_riscv32_mp_dmdata_out,
  output logic [3:0]                  ms_riscv32_mp_dmwr_mask_out,
  output logic                        ms_riscv32_mp_dmwr_req_out,
  output logic                        ms_riscv32_mp_dmrd_req_out,
  input  logic [31:0]                 ms_riscv32_mp_dmdata_in,
  input  logic                        ms_riscv32_mp_dmem_ready_in,
  output logic                        bus_err_out
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;
  typedef enum logic [0:0] {OwnCore, OwnDma} owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        we_q, we_d;
  logic [7:0]  starve_q, starve_d;
  logic        core_rvalid_q, core_rvalid_d;
  logic        dma_rvalid_q, dma_rvalid_d;
  logic [31:0] core_rdata_q, core_rdata_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  logic        bus_err_q, bus_err_d;

  logic core_gnt, dma_gnt, dma_wins, grant, busy, finish, timeout;

  assign busy = (state_q == StBusy);

  // DMA takes the port when the core is absent or has been favoured StarveLimit times in a row.
  always_comb begin
    dma_wins = dma_io.req && (!core_io.req || (starve_q >= 8'(StarveLimit)));
    core_gnt = (state_q == StIdle) && core_io.req && !dma_wins;
    dma_gnt  = (state_q == StIdle) && dma_wins;
    grant    = core_gnt || dma_gnt;
  end

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] to_q, to_d;

  assign timeout = busy && !ms_riscv32_mp_dmem_ready_in && (to_q == 8'(TimeoutCycles - 1));

  always_comb begin
    to_d = to_q;
    if (grant) begin
      to_d = '0;
    end else if (busy && !ms_riscv32_mp_dmem_ready_in) begin
      to_d = to_q + 8'd1;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign finish = busy && (ms_riscv32_mp_dmem_ready_in || timeout);

  // FSM: state register
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StBusy;
      StBusy:  if (finish) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    core_io.gnt                 = core_gnt;
    dma_io.gnt                  = dma_gnt;
    core_io.rvalid              = core_rvalid_q;
    dma_io.rvalid               = dma_rvalid_q;
    core_io.rdata               = core_rdata_q;
    dma_io.rdata                = dma_rdata_q;
    ms_riscv32_mp_dmaddr_out    = addr_q;
    ms_riscv32_mp_dmdata_out    = wdata_q;
    ms_riscv32_mp_dmwr_req_out  = busy && we_q;
    ms_riscv32_mp_dmrd_req_out  = busy && !we_q;
    ms_riscv32_mp_dmwr_mask_out = (busy && we_q) ? mask_q : 4'h0;
    bus_err_out                 = bus_err_q;
    core_stall_out              = (core_io.req && !core_gnt) || (busy && (owner_q == OwnCore));
  end

  // Transaction holding registers, starvation counter and completion responses.
  always_comb begin
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    we_d          = we_q;
    owner_d       = owner_q;
    starve_d      = starve_q;
    core_rdata_d  = core_rdata_q;
    dma_rdata_d   = dma_rdata_q;
    core_rvalid_d = finish && (owner_q == OwnCore);
    dma_rvalid_d  = finish && (owner_q == OwnDma);
    bus_err_d     = timeout;

    if (core_gnt) begin
      addr_d   = core_io.addr;
      wdata_d  = core_io.wdata;
      mask_d   = core_io.mask;
      we_d     = core_io.we;
      owner_d  = OwnCore;
      if (!dma_io.req) begin
        starve_d = '0;
      end else if (starve_q != 8'hFF) begin
        starve_d = starve_q + 8'd1;
      end
    end else if (dma_gnt) begin
      addr_d   = dma_io.addr;
      wdata_d  = dma_io.wdata;
      mask_d   = dma_io.mask;
      we_d     = dma_io.we;
      owner_d  = OwnDma;
      starve_d = '0;
    end

    if (finish && (timeout || !we_q)) begin
      if (owner_q == OwnCore) begin
        core_rdata_d = timeout ? 32'h0 : ms_riscv32_mp_dmdata_in;
      end else begin
        dma_rdata_d  = timeout ? 32'h0 : ms_riscv32_mp_dmdata_in;
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      mask_q        <= '0;
      we_q          <= 1'b0;
      owner_q       <= OwnCore;
      starve_q      <= '0;
      core_rdata_q  <= '0;
      dma_rdata_q   <= '0;
      core_rvalid_q <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      mask_q        <= mask_d;
      we_q          <= we_d;
      owner_q       <= owner_d;
      starve_q      <= starve_d;
      core_rdata_q  <= core_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
      core_rvalid_q <= core_rvalid_d;
      dma_rvalid_q  <= dma_rvalid_d;
      bus_err_q     <= bus_err_d;
    end
  end

endmodule
